tx_word_serializer: RTL and testbench
=====================================

// Module: tx_word_serializer
// PURPOSE
// - Generalised UART transmit sequencer: latches a DATA_W-bit word on a send request and
//   issues it to a byte-wide UART transmitter as NBYTES = DATA_W/8 consecutive bytes.
// - Byte order is selectable. An optional trailing XOR checksum byte is appended.
// - The tx_start/tx_busy handshake to the UART is supervised by an acknowledge timeout.
// - Sits between datapath producers (sample registers, status words) and uart_tx.
// PARAMETERS
// - DATA_W       16  word width; multiple of 8, range 8..64
// - MSB_FIRST    0   0: send byte 0 (bits 7:0) first; 1: send the most significant byte first
// - CHECKSUM_EN  0   1: append a byte equal to the XOR of all data bytes
// - ACK_TIMEOUT  16  cycles to wait for tx_busy to rise after tx_start before re-issuing
// PORTS
// - clk         in   1       system clock
// - reset       in   1       synchronous, active-high reset
// - send_req    in   1       request to send raw_data; sampled only while send_ready=1
// - raw_data    in   DATA_W  word to send; latched in the cycle send_req&&send_ready
// - send_ready  out  1       1 in IDLE only
// - tx_busy     in   1       UART busy flag
// - tx_start    out  1       one-cycle start pulse to the UART
// - tx_data     out  8       byte presented to the UART
// - done        out  1       one-cycle pulse after the last byte completes
// - retry_err   out  1       sticky flag: an acknowledge timeout has occurred; cleared by reset only
// BEHAVIOUR
// - One clock, clk. Reset is synchronous and active-high.
// - Reset values: state=IDLE, send_ready=1, tx_start=0, tx_data=8'h00, done=0, retry_err=0,
//   byte_idx=0, timer=0, checksum=0.
// - Reset asserted mid-transfer aborts the transfer immediately. No partial state is retained.
// - Total bytes per transfer: NTOT = NBYTES + CHECKSUM_EN.
// - IDLE: if send_req, latch raw_data into shreg, clear byte_idx and checksum, go to START.
//   send_ready drops on the next cycle.
// - START: tx_start=1 for exactly this cycle. tx_data = the selected byte. timer=0. Go to WAIT_ACK.
// - WAIT_ACK: tx_start=0.
//   - If tx_busy=1, go to WAIT_DONE.
//   - Otherwise timer++. When timer==ACK_TIMEOUT-1, set retry_err=1 and go to START
//     (re-issue the same byte).
// - WAIT_DONE: when tx_busy=0, do one of the following:
//   - If byte_idx==NTOT-1: go to IDLE and pulse done in the same cycle.
//   - Otherwise: byte_idx++, checksum ^= current data byte, go to START.
// - Byte select:
//   - data byte k = shreg[8k+7:8k] when MSB_FIRST=0, shreg[8(NBYTES-1-k)+7 -:8] when MSB_FIRST=1.
//   - Index NBYTES (checksum slot) outputs the checksum register.
// - tx_data is registered. It is stable from START through the end of WAIT_DONE of that byte.
// - Minimum latency per byte is 3 cycles plus UART busy time.
// - First tx_start occurs 1 cycle after the accepting send_req cycle.
// - send_req while not ready is ignored, not queued. raw_data changes after latch have no effect.
// - tx_busy already high when START issues: WAIT_ACK exits on the next cycle. Normal behaviour.
// - Back-to-back transfers: send_req held high is accepted in the cycle after done. Minimum
//   1 IDLE cycle between transfers.
// - DATA_W not a multiple of 8, or out of range: elaboration-time $error.
// STRUCTURE
// - Package tx_pkg:
//   - typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} tx_state_t.
//   - localparam UART_BYTE_W = 8.
//   - function nbytes(int w) returning w/8.
// - Single module. Two-process style: state/data registers plus next-state comb.
// - The ACK timer is a $clog2(ACK_TIMEOUT)-bit counter inline. No sub-module is warranted.
// TESTING
// - DATA_W=16, MSB_FIRST=0, send raw_data=16'hA55A; UART model busy 1 cycle after start for
//   10 cycles -> tx_data 8'h5A then 8'hA5, two tx_start pulses, done one cycle, retry_err=0.
// - DATA_W=32, MSB_FIRST=1, CHECKSUM_EN=1, raw_data=32'h1234_5678 -> bytes 12,34,56,78,
//   then 8'h08 (12^34^56^78).
// - UART model ignores the first tx_start, ACK_TIMEOUT=4 -> second tx_start exactly 5 cycles
//   after the first, same tx_data, retry_err=1.
// - send_req pulsed in WAIT_DONE with raw_data=16'hFFFF -> ignored; original word completes
//   unchanged; send_ready=0 throughout.
// - Reset asserted during WAIT_DONE of byte 1 -> next cycle all outputs at reset values;
//   a new send_req then restarts at byte 0.
// - send_req held high continuously -> transfers repeat, each done followed by exactly one
//   send_ready cycle, then tx_start.

Source files
------------

// File: rtl/tx_word_serializer_pkg.sv
// Shared types and helpers for the word-to-byte UART transmit sequencer.
package tx_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} tx_state_t;

  localparam int UART_BYTE_W = 8;

  function automatic int nbytes(int w);
    return w / UART_BYTE_W;
  endfunction

endpackage

// File: rtl/tx_word_serializer_if.sv
// Producer/UART-side signal bundle of tx_word_serializer; slave is the sequencer's view.
interface tx_word_serializer_if #(
  parameter int DATA_W = 16
);

  logic                          send_req;
  logic [DATA_W-1:0]             raw_data;
  logic                          send_ready;
  logic                          tx_busy;
  logic                          tx_start;
  logic [tx_pkg::UART_BYTE_W-1:0] tx_data;
  logic                          done;
  logic                          retry_err;

  modport master (
    output send_req, raw_data, tx_busy,
    input  send_ready, tx_start, tx_data, done, retry_err
  );

  modport slave (
    input  send_req, raw_data, tx_busy,
    output send_ready, tx_start, tx_data, done, retry_err
  );

endinterface

// File: rtl/tx_word_serializer.sv
// Latches a DATA_W-bit word and hands it to a byte UART one byte at a time,
// optionally followed by an XOR checksum byte, with ack-timeout re-issue.
module tx_word_serializer
  import tx_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter bit MSB_FIRST   = 1'b0,
  parameter bit CHECKSUM_EN = 1'b0,
  parameter int ACK_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  reset,
  tx_word_serializer_if.slave  bus
);

  localparam int NBYTES = nbytes(DATA_W);
  localparam int NTOT   = NBYTES + (CHECKSUM_EN ? 1 : 0);
  localparam int IW     = $clog2(NTOT + 1);
  localparam int TW     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_width
    $error("tx_word_serializer: DATA_W must be a multiple of 8 in 8..64");
  end

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     byte_idx_q, byte_idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        checksum_q, checksum_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              retry_err_q, retry_err_d;
  logic              done_c;

  // Index NBYTES (or any index past the data bytes) selects the checksum.
  function automatic logic [7:0] pick(logic [DATA_W-1:0] w, logic [IW-1:0] k,
                                      logic [7:0] cs);
    logic [7:0] b;
    b = cs;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (k == IW'(i)) b = MSB_FIRST ? w[8*(NBYTES-1-i) +: 8] : w[8*i +: 8];
    end
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      byte_idx_q  <= '0;
      timer_q     <= '0;
      checksum_q  <= '0;
      tx_data_q   <= '0;
      retry_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      byte_idx_q  <= byte_idx_d;
      timer_q     <= timer_d;
      checksum_q  <= checksum_d;
      tx_data_q   <= tx_data_d;
      retry_err_q <= retry_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    byte_idx_d  = byte_idx_q;
    timer_d     = timer_q;
    checksum_d  = checksum_q;
    retry_err_d = retry_err_q;
    done_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.send_req) begin
          shreg_d    = bus.raw_data;
          byte_idx_d = '0;
          checksum_d = '0;
          state_d    = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          retry_err_d = 1'b1;
          state_d     = START;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (byte_idx_q == IW'(NTOT - 1)) begin
            done_c  = 1'b1;
            state_d = IDLE;
          end else begin
            checksum_d = checksum_q ^ pick(shreg_q, byte_idx_q, checksum_q);
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Load the byte on entry to START from next-state values so it is valid
    // during the tx_start cycle itself and held until the byte completes.
    tx_data_d = (state_d == START) ? pick(shreg_d, byte_idx_d, checksum_d) : tx_data_q;
  end

  assign bus.send_ready = (state_q == IDLE);
  assign bus.tx_start   = (state_q == START);
  assign bus.tx_data    = tx_data_q;
  assign bus.done       = done_c;
  assign bus.retry_err  = retry_err_q;

endmodule

// File: tb/tb_tx_word_serializer.sv
// Self-checking bench: 16-bit LSB-first (short ack timeout) and 32-bit MSB-first with checksum.
module tb_tx_word_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tx_word_serializer_if #(.DATA_W(16)) bus_a ();
  tx_word_serializer_if #(.DATA_W(32)) bus_b ();

  tx_word_serializer #(.DATA_W(16), .MSB_FIRST(1'b0), .CHECKSUM_EN(1'b0), .ACK_TIMEOUT(4))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  tx_word_serializer #(.DATA_W(32), .MSB_FIRST(1'b1), .CHECKSUM_EN(1'b1), .ACK_TIMEOUT(16))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int ignore_a = 0;
  logic busy_a = 1'b0;
  logic busy_b = 1'b0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  int starts_a[$];

  assign bus_a.tx_busy = busy_a;
  assign bus_b.tx_busy = busy_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART models: busy rises one cycle after tx_start and stays high for 10 cycles.
  initial forever begin
    @(posedge clk); #1;
    if (bus_a.tx_start) begin
      if (ignore_a > 0) ignore_a--;
      else begin
        @(posedge clk); #1; busy_a = 1'b1;
        repeat (10) @(posedge clk);
        #1; busy_a = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (bus_b.tx_start) begin
      @(posedge clk); #1; busy_b = 1'b1;
      repeat (10) @(posedge clk);
      #1; busy_b = 1'b0;
    end
  end

  // Scoreboard monitor: every tx_start pops the next expected byte.
  initial forever begin
    @(negedge clk);
    if (!reset && bus_a.tx_start) begin
      starts_a.push_back(cyc);
      if (sb_a.size() == 0) begin
        tests++; failed++;
        $display("FAIL a_extra_start: got tx_data %0h expected no tx_start", bus_a.tx_data);
      end else chk("a_byte", bus_a.tx_data, sb_a.pop_front());
    end
    if (!reset && bus_b.tx_start) begin
      if (sb_b.size() == 0) begin
        tests++; failed++;
        $display("FAIL b_extra_start: got tx_data %0h expected no tx_start", bus_b.tx_data);
      end else chk("b_byte", bus_b.tx_data, sb_b.pop_front());
    end
  end

  task automatic wait_done(input bit b, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      found = b ? bus_b.done : bus_a.done;
    end
    chk(name, found, 1'b1);
  endtask

  task automatic send_a(input logic [15:0] w);
    bus_a.raw_data = w;
    bus_a.send_req = 1'b1;
    @(negedge clk);
    bus_a.send_req = 1'b0;
  endtask

  typedef struct {
    bit          sel_b;
    logic [31:0] raw;
    int          nb;
    logic [39:0] exp;   // expected bytes in transmit order, first byte in [7:0]
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{1'b0, 32'h0000_A55A, 2, 40'h00_0000_A55A};
    vecs[1] = '{1'b0, 32'h0000_0001, 2, 40'h00_0000_0001};
    vecs[2] = '{1'b0, 32'h0000_C30F, 2, 40'h00_0000_C30F};
    vecs[3] = '{1'b1, 32'h1234_5678, 5, 40'h08_7856_3412};
    vecs[4] = '{1'b1, 32'hDEAD_BEEF, 5, 40'h22_EFBE_ADDE};
    vecs[5] = '{1'b1, 32'h0000_0000, 5, 40'h00_0000_0000};
    vecs[6] = '{1'b1, 32'hFF00_FF00, 5, 40'h00_00FF_00FF};
    vecs[7] = '{1'b1, 32'h8000_0001, 5, 40'h81_0100_0080};

    bus_a.send_req = 1'b0; bus_a.raw_data = '0;
    bus_b.send_req = 1'b0; bus_b.raw_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus_a.send_ready, 1'b1);
    chk("rst_start", bus_a.tx_start, 1'b0);
    chk("rst_data", bus_a.tx_data, 8'h00);
    chk("rst_done", bus_a.done, 1'b0);
    chk("rst_retry", bus_a.retry_err, 1'b0);
    chk("rst_b_ready", bus_b.send_ready, 1'b1);

    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].nb; i++) begin
        if (vecs[v].sel_b) sb_b.push_back(vecs[v].exp[8*i +: 8]);
        else sb_a.push_back(vecs[v].exp[8*i +: 8]);
      end
      if (vecs[v].sel_b) begin
        bus_b.raw_data = vecs[v].raw;
        bus_b.send_req = 1'b1;
        @(negedge clk);
        bus_b.send_req = 1'b0;
        wait_done(1'b1, 200, "vec_done_b");
        chk("vec_retry_b", bus_b.retry_err, 1'b0);
        chk("vec_sb_b_empty", sb_b.size(), 0);
      end else begin
        send_a(vecs[v].raw[15:0]);
        wait_done(1'b0, 100, "vec_done_a");
        chk("vec_retry_a", bus_a.retry_err, 1'b0);
        chk("vec_sb_a_empty", sb_a.size(), 0);
      end
      @(negedge clk);
    end

    // Ack timeout: first start ignored, byte re-issued 5 cycles later.
    ignore_a = 1;
    sb_a.push_back(8'h5A); sb_a.push_back(8'h5A); sb_a.push_back(8'hA5);
    starts_a.delete();
    send_a(16'hA55A);
    wait_done(1'b0, 100, "retry_done");
    chk("retry_err", bus_a.retry_err, 1'b1);
    chk("retry_nstarts", starts_a.size(), 3);
    if (starts_a.size() >= 2) chk("retry_gap", starts_a[1] - starts_a[0], 5);
    @(negedge clk);

    // send_req while busy is ignored.
    sb_a.push_back(8'h34); sb_a.push_back(8'h12);
    send_a(16'h1234);
    n = 0;
    while (!bus_a.tx_start && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    bus_a.raw_data = 16'hFFFF;
    bus_a.send_req = 1'b1;
    chk("ign_ready0", bus_a.send_ready, 1'b0);
    @(negedge clk);
    bus_a.send_req = 1'b0;
    chk("ign_ready1", bus_a.send_ready, 1'b0);
    wait_done(1'b0, 100, "ign_done");
    chk("ign_sb_empty", sb_a.size(), 0);
    repeat (3) @(negedge clk);
    chk("ign_idle", bus_a.send_ready, 1'b1);

    // Reset during WAIT_DONE of byte 1, then a fresh transfer from byte 0.
    sb_a.push_back(8'h34); sb_a.push_back(8'h12);
    send_a(16'h1234);
    n = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      if (bus_a.tx_start) n++;
      if (n < 2) @(negedge clk);
    end
    chk("mid_two_starts", n, 2);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_ready", bus_a.send_ready, 1'b1);
    chk("mid_start", bus_a.tx_start, 1'b0);
    chk("mid_data", bus_a.tx_data, 8'h00);
    chk("mid_done", bus_a.done, 1'b0);
    chk("mid_retry", bus_a.retry_err, 1'b0);
    n = 0;
    while (busy_a && n < 30) begin @(negedge clk); n++; end
    @(negedge clk);
    sb_a.push_back(8'h5A); sb_a.push_back(8'hA5);
    send_a(16'hA55A);
    wait_done(1'b0, 100, "mid_restart_done");
    chk("mid_sb_empty", sb_a.size(), 0);
    @(negedge clk);

    // send_req held high: one send_ready cycle after each done, then tx_start.
    for (int i = 0; i < 3; i++) begin sb_a.push_back(8'h1E); sb_a.push_back(8'h0F); end
    bus_a.raw_data = 16'h0F1E;
    bus_a.send_req = 1'b1;
    for (int d = 0; d < 3; d++) begin
      wait_done(1'b0, 100, "b2b_done");
      if (d < 2) begin
        @(negedge clk);
        chk("b2b_gap_ready", bus_a.send_ready, 1'b1);
        chk("b2b_gap_start", bus_a.tx_start, 1'b0);
        @(negedge clk);
        chk("b2b_start", bus_a.tx_start, 1'b1);
        chk("b2b_not_ready", bus_a.send_ready, 1'b0);
      end else begin
        bus_a.send_req = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_end_ready", bus_a.send_ready, 1'b1);
    @(negedge clk);
    chk("b2b_end_idle", bus_a.tx_start, 1'b0);
    chk("b2b_sb_empty", sb_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
